// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment display driver.
// Scans DIGITS digits, one per REFRESH_DIV-cycle slot, using a value captured on load.
// Features: leading-zero blanking, per-digit decimal points, a display enable, and an
// anti-ghosting guard that keeps all anodes off at the start of each slot.
// All display outputs are registered. They follow the internal state with one cycle of latency.
module seg7_scan_driver #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD       = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  blank_lz,
   input  logic                  en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     anode,
   output logic [2:0]            digit_idx
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]         cnt_q;
   logic [IW-1:0]         idx_q;
   logic [4*DIGITS-1:0]   shadow_q;

   logic [DIGITS-1:0]     upper_zero;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic                  guard_active;
   logic                  slot_end;

   // Active-low glyphs in {g,f,e,d,c,b,a} order.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // upper_zero[i] is set when nibbles i..DIGITS-1 of the shadow are all zero.
   always_comb begin
      logic all_zero;
      all_zero   = 1'b1;
      upper_zero = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero      = all_zero & (shadow_q[4*i +: 4] == 4'h0);
         upper_zero[i] = all_zero;
      end
   end

   // Select the nibble, decimal point and blanking state of the digit being scanned.
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib   = shadow_q[4*i +: 4];
            cur_dp    = dp_mask[i];
            // Digit 0 is never blanked, so a zero value still shows "0".
            cur_blank = blank_lz && (i != 0) && upper_zero[i];
         end
      end
   end

   assign guard_active = (32'(cnt_q) < GUARD);
   assign slot_end     = (cnt_q == CW'(REFRESH_DIV - 1));

   // Refresh counter, digit index and shadow register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
      end else begin
         if (slot_end) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (load) begin
            shadow_q <= value;
         end
      end
   end

   // Registered cathode and anode drive, computed from the state present at this edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seg   <= 7'h7F;
         dp    <= 1'b1;
         anode <= '1;
      end else if (!en || guard_active) begin
         seg   <= 7'h7F;
         dp    <= 1'b1;
         anode <= '1;
      end else begin
         seg   <= cur_blank ? 7'h7F : hex_glyph(cur_nib);
         dp    <= ~cur_dp;
         anode <= ~(DIGITS'(1) << idx_q);
      end
   end

   // The scan index is presented zero-extended to a fixed 3-bit width.
   always_comb begin
      digit_idx           = '0;
      digit_idx[IW-1:0]   = idx_q;
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=4, GUARD=1.
// ph tracks the output phase within a 16-cycle frame. Output digit = ph/4, and ph%4==0 is the guard cycle.
// Glyph and decimal-point values for each scenario are written out by hand.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp_mask;
   logic        blank_lz;
   logic        en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  anode;
   logic [2:0]  digit_idx;

   int n_assert = 0;
   int n_fail   = 0;
   int ph       = 0;

   logic [6:0] exp_glyph [4];
   logic       exp_dp    [4];
   logic       disp_on;

   seg7_scan_driver #(
      .DIGITS      (4),
      .REFRESH_DIV (4),
      .GUARD       (1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .value     (value),
      .load      (load),
      .dp_mask   (dp_mask),
      .blank_lz  (blank_lz),
      .en        (en),
      .seg       (seg),
      .dp        (dp),
      .anode     (anode),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ph = (ph + 1) % 16;
   endtask

   task automatic check_rst(input string tag);
      chk({tag, " anode"}, 32'(anode), 32'h0000000F);
      chk({tag, " seg"}, 32'(seg), 32'h0000007F);
      chk({tag, " dp"}, 32'(dp), 32'h00000001);
      chk({tag, " digit_idx"}, 32'(digit_idx), 32'h00000000);
   endtask

   task automatic check_ph();
      logic       off;
      int         d;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      d   = ph / 4;
      off = !disp_on || (ph % 4 == 0);
      ea  = off ? 4'hF : ~(4'b0001 << d);
      es  = off ? 7'h7F : exp_glyph[d];
      ed  = off ? 1'b1 : exp_dp[d];
      chk($sformatf("anode ph%0d", ph), 32'(anode), 32'(ea));
      chk($sformatf("seg ph%0d", ph), 32'(seg), 32'(es));
      chk($sformatf("dp ph%0d", ph), 32'(dp), 32'(ed));
      chk($sformatf("digit_idx ph%0d", ph), 32'(digit_idx), 32'(((ph + 1) % 16) / 4));
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick();
         check_ph();
      end
   endtask

   task automatic run_to(input int p);
      while (ph != p) begin
         tick();
         check_ph();
      end
   endtask

   // The new value takes effect on the output update one cycle after the load edge.
   task automatic load_val(input logic [15:0] v);
      load  = 1'b1;
      value = v;
      tick();
      load  = 1'b0;
      tick();
   endtask

   task automatic set_tab(input logic [6:0] g3, input logic [6:0] g2,
                          input logic [6:0] g1, input logic [6:0] g0, input logic [3:0] m);
      exp_glyph[3] = g3;
      exp_glyph[2] = g2;
      exp_glyph[1] = g1;
      exp_glyph[0] = g0;
      for (int i = 0; i < 4; i++) exp_dp[i] = ~m[i];
   endtask

   initial begin
      // Reset held with load/en active. The shadow register must stay zero.
      reset_n  = 1'b0;
      load     = 1'b1;
      value    = 16'hFFFF;
      en       = 1'b1;
      blank_lz = 1'b0;
      dp_mask  = 4'b0000;
      disp_on  = 1'b1;
      repeat (5) begin
         tick();
         check_rst("reset");
      end

      // Release: the first output is the digit-0 guard, and a zero shadow shows "0" everywhere.
      reset_n = 1'b1;
      load    = 1'b0;
      tick();
      ph = 0;
      set_tab(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b0000);
      check_ph();
      run(15);

      // Plain scan of 1234.
      load_val(16'h1234);
      set_tab(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 4'b0000);
      run(32);

      // Leading-zero blanking.
      blank_lz = 1'b1;
      load_val(16'h0050);
      set_tab(7'h7F, 7'h7F, 7'b0010010, 7'b1000000, 4'b0000);
      run(16);
      load_val(16'h0000);
      set_tab(7'h7F, 7'h7F, 7'h7F, 7'b1000000, 4'b0000);
      run(16);

      // Decimal point on digit 2 only.
      blank_lz = 1'b0;
      dp_mask  = 4'b0100;
      load_val(16'h9ABC);
      set_tab(7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 4'b0100);
      run(16);

      // Drop en while the state is at counter=2 of digit 1.
      run_to(5);
      en      = 1'b0;
      disp_on = 1'b0;
      run_to(12);
      // Raise en while the state is in digit 3.
      en      = 1'b1;
      disp_on = 1'b1;
      run(1);
      // Load E000 mid-slot on digit 3.
      load  = 1'b1;
      value = 16'hE000;
      run(1);
      load  = 1'b0;
      exp_glyph[3] = 7'b0000110;
      run(1);
      set_tab(7'b0000110, 7'b1000000, 7'b1000000, 7'b1000000, 4'b0100);
      run(16);

      // Reset during the digit-2 active window.
      run_to(9);
      reset_n = 1'b0;
      tick();
      check_rst("midreset");
      reset_n  = 1'b1;
      blank_lz = 1'b1;
      tick();
      ph = 0;
      // The shadow is back to zero. Blanked digits keep their anode and decimal point.
      set_tab(7'h7F, 7'h7F, 7'h7F, 7'b1000000, 4'b0100);
      check_ph();
      run(15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
